mux_arb_rr: RTL and testbench

Parametrised N-way, W-bit arbitrating multiplexer. It is the registered, handshaked successor to the fixed 4-way 16-bit select mux. It picks one valid input channel per cycle using round-robin priority and registers that channel's word into a one-entry output stage with valid/ready flow control. It sits between multiple word producers (e.g. memory-mapped peripherals, instruction/data sources) and a single consumer on the 16-bit datapath.

---
 rtl/mux_arb_pkg.sv | 12 +
 rtl/mux_arb_rr_pick.sv | 31 +++
 rtl/mux_arb_rr.sv | 110 +++++++++++
 tb/tb_mux_arb_rr.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants and the round-robin pointer wrap helper for the mux_arb_rr slice.
package mux_arb_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_N     = 4;

    // Pointer advances past the granted channel; wraps to 0 for any N, power of two or not
    function automatic int next_ptr(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin picker: first requesting channel at or after ptr, wrapping at N.
module rr_pick #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt_onehot,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    // Scan offsets from farthest to nearest so the closest requester to ptr is the final winner
    always_comb begin
        int ch;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        ch         = 0;
        for (int k = N - 1; k >= 0; k--) begin
            ch = int'(ptr) + k;
            if (ch >= N) ch = ch - N;
            if (ch < N && req[ch]) begin
                gnt_idx = SELW'(ch);
                any     = 1'b1;
            end
        end
        if (any) gnt_onehot[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/mux_arb_rr.sv
// N-way round-robin arbitrating mux with a one-entry registered valid/ready output stage.
// Optional MUX_ARB_FORCE_SEL_EN adds force_en/force_sel to bypass arbitration with a fixed select.
module mux_arb_rr
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef MUX_ARB_FORCE_SEL_EN
    input  logic                 force_en,
    input  logic [SELW-1:0]      force_sel,
`endif
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic             valid_q, valid_d;

    logic [N-1:0]     rr_onehot;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;

    logic             accept;
    logic             grant_any;
    logic [SELW-1:0]  grant_idx;
    logic [N-1:0]     grant_onehot;
    logic             grant_moves_ptr;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req        (in_valid),
        .ptr        (ptr_q),
        .gnt_onehot (rr_onehot),
        .gnt_idx    (rr_idx),
        .any        (rr_any)
    );

    assign accept = !valid_q || out_ready;

    // Forced select replaces the picker but still obeys the accept rule and freezes the pointer
    always_comb begin
        grant_any       = rr_any;
        grant_idx       = rr_idx;
        grant_onehot    = rr_onehot;
        grant_moves_ptr = 1'b1;
`ifdef MUX_ARB_FORCE_SEL_EN
        if (force_en) begin
            grant_idx       = force_sel;
            grant_onehot    = '0;
            grant_moves_ptr = 1'b0;
            grant_any       = 1'b0;
            if (int'(force_sel) < N) begin
                grant_any = in_valid[force_sel];
                grant_onehot[force_sel] = in_valid[force_sel];
            end
        end
`endif
    end

    assign in_ready = (!reset && accept && grant_any) ? grant_onehot : '0;

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (accept) begin
            if (grant_any) begin
                data_d  = in_data[grant_idx*WIDTH +: WIDTH];
                sel_d   = grant_idx;
                valid_d = 1'b1;
                if (grant_moves_ptr) ptr_d = SELW'(next_ptr(int'(grant_idx), N));
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Bench for mux_arb_rr: a 4-way and a 3-way instance against a modulo-arithmetic reference model.
module tb_mux_arb_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  vld  [2];
    logic [63:0] dat  [2];
    logic        ordy [2];
    logic        fEn  [2];
    logic [1:0]  fSel [2];

    logic [3:0]  irA;
    logic [2:0]  irB;
    logic [15:0] odA, odB;
    logic [1:0]  osA, osB;
    logic        ovA, ovB;

    int assertions = 0;
    int failures   = 0;

    int nCh  [2] = '{4, 3};
    int mPtr [2];
    int mOv  [2];
    int mOd  [2];
    int mOs  [2];

    always #5 clk = ~clk;

    mux_arb_rr #(.WIDTH(16), .N(4)) dutA (
        .clk       (clk),
        .reset     (reset),
`ifdef MUX_ARB_FORCE_SEL_EN
        .force_en  (fEn[0]),
        .force_sel (fSel[0]),
`endif
        .in_data   (dat[0]),
        .in_valid  (vld[0]),
        .in_ready  (irA),
        .out_data  (odA),
        .out_sel   (osA),
        .out_valid (ovA),
        .out_ready (ordy[0])
    );

    mux_arb_rr #(.WIDTH(16), .N(3)) dutB (
        .clk       (clk),
        .reset     (reset),
`ifdef MUX_ARB_FORCE_SEL_EN
        .force_en  (fEn[1]),
        .force_sel (fSel[1]),
`endif
        .in_data   (dat[1][47:0]),
        .in_valid  (vld[1][2:0]),
        .in_ready  (irB),
        .out_data  (odB),
        .out_sel   (osB),
        .out_valid (ovB),
        .out_ready (ordy[1])
    );

    // Reference grant: walk channels ptr, ptr+1, ... modulo n; forced mode allows only one channel
    function automatic int pick(input logic [3:0] v, input int p, input int n,
                                input logic f, input int fs);
        int ch;
        if (f) return (fs < n && v[fs]) ? fs : -1;
        for (int k = 0; k < n; k++) begin
            ch = (p + k) % n;
            if (v[ch]) return ch;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational in_ready, clock the edge, advance model, check registered outputs
    task automatic applyStimulus();
        int g [2];
        int exIr;
        logic f;
        #1;
        for (int i = 0; i < 2; i++) begin
            f = 1'b0;
`ifdef MUX_ARB_FORCE_SEL_EN
            f = fEn[i];
`endif
            g[i] = pick(vld[i], mPtr[i], nCh[i], f, int'(fSel[i]));
            if (reset || !(mOv[i] == 0 || ordy[i]) || g[i] < 0) exIr = 0;
            else exIr = 1 << g[i];
            checkOutput($sformatf("in_ready[%0d]", i), (i == 0) ? 32'(irA) : 32'(irB), exIr);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            f = 1'b0;
`ifdef MUX_ARB_FORCE_SEL_EN
            f = fEn[i];
`endif
            if (reset) begin
                mPtr[i] = 0; mOv[i] = 0; mOd[i] = 0; mOs[i] = 0;
            end else if (mOv[i] == 0 || ordy[i]) begin
                if (g[i] >= 0) begin
                    mOd[i] = int'(dat[i][g[i]*16 +: 16]);
                    mOs[i] = g[i];
                    mOv[i] = 1;
                    if (!f) mPtr[i] = (g[i] + 1) % nCh[i];
                end else begin
                    mOv[i] = 0;
                end
            end
        end
        #1;
        checkOutput("out_valid[0]", 32'(ovA), mOv[0]);
        checkOutput("out_data[0]",  32'(odA), mOd[0]);
        checkOutput("out_sel[0]",   32'(osA), mOs[0]);
        checkOutput("out_valid[1]", 32'(ovB), mOv[1]);
        checkOutput("out_data[1]",  32'(odB), mOd[1]);
        checkOutput("out_sel[1]",   32'(osB), mOs[1]);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mPtr[i] = 0; mOv[i] = 0; mOd[i] = 0; mOs[i] = 0;
            vld[i]  = 4'hF;
            ordy[i] = 1'b1;
            fEn[i]  = 1'b0;
            fSel[i] = 2'd0;
            for (int c = 0; c < 4; c++) dat[i][c*16 +: 16] = 16'h00A0 + 16'(c);
        end

        // Reset held two cycles with every channel offering a word
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        vld[1] = 4'h0;

        // All valid with ready high: expect 0,1,2,3,0 on the 4-way instance
        for (int c = 0; c < 5; c++) applyStimulus();

        // Backpressure: output held, nothing accepted, then next channel on release
        ordy[0] = 1'b0;
        for (int c = 0; c < 3; c++) applyStimulus();
        ordy[0] = 1'b1;
        applyStimulus();
        applyStimulus();

        // Sparse wrap on the 3-way instance: steer ptr to 2, then only channels 2 and 0 request
        vld[0] = 4'h0;
        vld[1] = 4'b0010;
        applyStimulus();
        vld[1] = 4'b0101;
        for (int c = 0; c < 4; c++) applyStimulus();

        // Randomized traffic on both instances
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < 2; i++) begin
                vld[i]  = 4'($urandom_range(0, 15));
                dat[i]  = {$urandom, $urandom};
                ordy[i] = ($urandom_range(0, 3) != 0);
            end
            applyStimulus();
        end

        // Reset while a word is held under backpressure drops it
        for (int i = 0; i < 2; i++) begin
            vld[i] = 4'hF; ordy[i] = 1'b1;
        end
        applyStimulus();
        ordy[0] = 1'b0; ordy[1] = 1'b0;
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        vld[0] = 4'h0; vld[1] = 4'h0;
        ordy[0] = 1'b1; ordy[1] = 1'b1;
        applyStimulus();
        vld[0] = 4'hF; vld[1] = 4'hF;
        applyStimulus();

`ifdef MUX_ARB_FORCE_SEL_EN
        // Forced select: only channel 2 on the 4-way, out-of-range select on the 3-way
        fEn[0] = 1'b1; fSel[0] = 2'd2;
        fEn[1] = 1'b1; fSel[1] = 2'd3;
        for (int c = 0; c < 4; c++) applyStimulus();
        fEn[0] = 1'b0; fEn[1] = 1'b0;
        for (int c = 0; c < 3; c++) applyStimulus();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
